// File: rtl/pa_rvfpm.sv
// pa_rvfpm: shared types and constants for the X-interface result path.
// Supplies the result payload layout, the output FSM state encoding and
// the default buffer depth. Also provides fallback values for the
// X_ID_WIDTH and FLEN macros when the build does not set them.

`ifndef X_ID_WIDTH
`define X_ID_WIDTH 4
`endif

`ifndef FLEN
`define FLEN 32
`endif

package pa_rvfpm;

  localparam int unsigned DEPTH_DEF      = 4;
  localparam int unsigned X_ID_WIDTH_DEF = `X_ID_WIDTH;
  localparam int unsigned FLEN_DEF       = `FLEN;
  localparam int unsigned RD_WIDTH       = 5;
  localparam int unsigned ECSWE_WIDTH    = 3;
  localparam int unsigned ECSDATA_WIDTH  = 6;

  typedef struct packed {
    logic [X_ID_WIDTH_DEF-1:0] id;
    logic [FLEN_DEF-1:0]       data;
    logic [RD_WIDTH-1:0]       rd;
    logic                      we;
    logic [ECSWE_WIDTH-1:0]    ecswe;
    logic [ECSDATA_WIDTH-1:0]  ecsdata;
  } x_result_t;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PRESENT = 2'd1,
    ST_DROP    = 2'd2
  } out_state_e;

endpackage

// File: rtl/xif_result_fifo.sv
// xif_result_fifo: circular storage for pending results.
// Holds the payload memory, the read/write pointers and the occupancy
// count. Exposes the head entry and the one behind it, so the owner can
// pick the next head in the same cycle that the current one is popped.

module xif_result_fifo
  import pa_rvfpm::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned WIDTH = 8
) (
  input  logic                   ck,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       head,
  output logic [WIDTH-1:0]       second,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;

  // Payload storage; the owner only pushes while there is room.
  always_ff @(posedge ck) begin
    if (push) begin
      mem[wptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge ck) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head   = mem[rptr];
  assign second = mem[rptr + AW'(1)];

endmodule

// File: rtl/xif_result_buffer.sv
// xif_result_buffer: buffers FPU results and offers them to the core in order.
// Optional feature macro RESULT_KILL_FILTER_EN: when defined, a killed-ID
// table is kept and killed entries are silently discarded via the DROP
// state; when undefined, every pushed entry is presented and the commit
// inputs are ignored.

module xif_result_buffer
  import pa_rvfpm::*;
#(
  parameter int unsigned DEPTH      = DEPTH_DEF,
  parameter int unsigned X_ID_WIDTH = `X_ID_WIDTH,
  parameter int unsigned FLEN       = `FLEN
) (
  input  logic                     ck,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [X_ID_WIDTH-1:0]    in_id,
  input  logic [FLEN-1:0]          in_data,
  input  logic [RD_WIDTH-1:0]      in_rd,
  input  logic                     in_we,
  input  logic [ECSWE_WIDTH-1:0]   in_ecswe,
  input  logic [ECSDATA_WIDTH-1:0] in_ecsdata,
  input  logic                     commit_valid,
  input  logic [X_ID_WIDTH-1:0]    commit_id,
  input  logic                     commit_kill,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [X_ID_WIDTH-1:0]    out_id,
  output logic [FLEN-1:0]          out_data,
  output logic [RD_WIDTH-1:0]      out_rd,
  output logic                     out_we,
  output logic [ECSWE_WIDTH-1:0]   out_ecswe,
  output logic [ECSDATA_WIDTH-1:0] out_ecsdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop_pulse
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned PW    = X_ID_WIDTH + FLEN + RD_WIDTH + 1 + ECSWE_WIDTH + ECSDATA_WIDTH;

  logic [PW-1:0]    in_pl;
  logic [PW-1:0]    head_pl;
  logic [PW-1:0]    second_pl;
  logic [PW-1:0]    cand_pl;
  logic [PW-1:0]    out_pl_q;
  logic [PW-1:0]    out_pl_d;
  logic [CNT_W-1:0] remaining;
  logic             push;
  logic             pop;
  logic             cand_ok;
  logic             cand_killed;
  out_state_e       state_q;
  out_state_e       state_d;

  assign in_pl    = {in_id, in_data, in_rd, in_we, in_ecswe, in_ecsdata};
  assign in_ready = !rst && (count < CNT_W'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = ((state_q == ST_PRESENT) && out_ready) || (state_q == ST_DROP);

  xif_result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PW)
  ) u_fifo (
    .ck     (ck),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .wdata  (in_pl),
    .head   (head_pl),
    .second (second_pl),
    .count  (count)
  );

  // Next head candidate: whatever stays in storage after this cycle's pop,
  // or the incoming push when storage drains, which gives one-cycle latency.
  always_comb begin
    remaining = count - CNT_W'(pop);
    cand_ok   = 1'b1;
    cand_pl   = in_pl;
    if (remaining != '0) begin
      cand_pl = pop ? second_pl : head_pl;
    end else if (!push) begin
      cand_ok = 1'b0;
    end
  end

`ifdef RESULT_KILL_FILTER_EN
  logic [(2**X_ID_WIDTH)-1:0] killed_q;
  logic [(2**X_ID_WIDTH)-1:0] killed_d;

  // Dropping clears the head's bit; a commit update is applied afterwards so a same-cycle kill wins.
  always_comb begin
    killed_d = killed_q;
    if (state_q == ST_DROP) begin
      killed_d[head_pl[PW-1 -: X_ID_WIDTH]] = 1'b0;
    end
    if (commit_valid) begin
      killed_d[commit_id] = commit_kill;
    end
  end

  // Killed-ID table register.
  always_ff @(posedge ck) begin
    if (rst) begin
      killed_q <= '0;
    end else begin
      killed_q <= killed_d;
    end
  end

  assign cand_killed = killed_d[cand_pl[PW-1 -: X_ID_WIDTH]];
  assign drop_pulse  = !rst && (state_q == ST_DROP);
`else
  logic unused_commit;

  assign unused_commit = ^{commit_valid, commit_id, commit_kill};
  assign cand_killed   = 1'b0;
  assign drop_pulse    = 1'b0;
`endif

  // Output FSM: an offered result is held until accepted; otherwise pick the next state from the candidate.
  always_comb begin
    state_d  = state_q;
    out_pl_d = out_pl_q;
    if ((state_q != ST_PRESENT) || out_ready) begin
      if (!cand_ok) begin
        state_d = ST_EMPTY;
      end else if (cand_killed) begin
        state_d = ST_DROP;
      end else begin
        state_d  = ST_PRESENT;
        out_pl_d = cand_pl;
      end
    end
  end

  // State and registered head payload.
  always_ff @(posedge ck) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      out_pl_q <= '0;
    end else begin
      state_q  <= state_d;
      out_pl_q <= out_pl_d;
    end
  end

  assign out_valid = !rst && (state_q == ST_PRESENT);
  assign {out_id, out_data, out_rd, out_we, out_ecswe, out_ecsdata} = out_pl_q;

endmodule

// File: doc/xif_result_buffer.md
XIF_RESULT_BUFFER -- requirements
Module: xif_result_buffer

Interface
REQ-001 Parameter: DEPTH, default 4, number of result entries (power of two, >=2).
REQ-002 Parameter: X_ID_WIDTH, default `X_ID_WIDTH, instruction ID width.
REQ-003 Parameter: FLEN, default `FLEN, result data width.
REQ-004 Port: ck  input  1  clock; single clock domain, all state updates on rising edge.
REQ-005 Port: rst  input  1  reset; synchronous, active-high.
REQ-006 Ports: in_valid input 1, in_ready output 1; FPU-side result handshake.
REQ-007 Ports: in_id input X_ID_WIDTH, in_data input FLEN, in_rd input 5, in_we input 1, in_ecswe input 3, in_ecsdata input 6; result payload.
REQ-008 Ports: commit_valid input 1, commit_id input X_ID_WIDTH, commit_kill input 1; core commit interface.
REQ-009 Ports: out_valid output 1, out_ready input 1; core-side result handshake.
REQ-010 Ports: out_id, out_data, out_rd, out_we, out_ecswe, out_ecsdata, outputs, widths as REQ-007; registered head payload.
REQ-011 Ports: count output $clog2(DEPTH)+1 occupancy; drop_pulse output 1, high one cycle per discarded entry.

Function
REQ-012 Transfer occurs when valid and ready are both high at a rising edge, on each side.
REQ-013 in_ready SHALL be high iff count < DEPTH; no same-cycle bypass when full.
REQ-014 Push writes payload at write pointer; pointers wrap modulo DEPTH; count +1 push, -1 pop, unchanged on simultaneous push and pop.
REQ-015 Output FSM states: EMPTY, PRESENT, DROP.
REQ-016 EMPTY: out_valid=0; go to PRESENT (head not killed) or DROP (head killed) when count>0.
REQ-017 PRESENT: out_valid=1, payload from head, stable until handshake; on out_ready pop, next state by REQ-016 using remaining entries.
REQ-018 DROP: out_valid=0, head popped in that cycle, drop_pulse=1, its killed bit cleared; next state by REQ-016.
REQ-019 Minimum latency: entry pushed in cycle N into empty buffer presents out_valid in cycle N+1.
REQ-020 Killed table: 2^X_ID_WIDTH bits; commit_valid with commit_kill=1 sets bit commit_id; commit_kill=0 clears it.
REQ-021 Kill for the head ID arriving while in PRESENT SHALL NOT retract out_valid; result already offered is delivered.
REQ-022 Kill and push of same ID in same cycle: entry is killed; kill for ID not yet pushed is retained until that entry reaches head.
REQ-023 Simultaneous set (kill) and clear (DROP) of same bit: set wins.
REQ-024 count never exceeds DEPTH; push with in_ready=0 is ignored (no overwrite).

Reset
REQ-025 On rst: pointers, count=0, state=EMPTY, out_valid=0, drop_pulse=0, killed table cleared, out_* payload 0, in_ready=1 from next cycle.
REQ-026 rst mid-transfer discards all entries; no handshake completes in a reset cycle.

Configuration
REQ-027 Macro RESULT_KILL_FILTER_EN: defined -> killed table and DROP state as above.
REQ-028 Undefined -> no killed table, DROP unreachable, drop_pulse tied 0, commit_* ports present but ignored; every pushed entry is presented.

Structure
REQ-029 x_result_t field widths, FSM state enum, and default DEPTH constant SHALL live in pa_rvfpm.
REQ-030 Storage SHALL be a sub-module xif_result_fifo (pointers, count, memory); xif_result_buffer holds FSM and killed table.

Verification
REQ-031 Reset then push id=3,data=0x3F800000,rd=5 with out_ready=1 -> out_valid at next cycle with same payload, count returns to 0.
REQ-032 Push 4 entries with out_ready=0 -> count=4, in_ready=0; fifth push ignored; drain yields ids in push order.
REQ-033 Push id=2, commit id=2 kill=1 before head -> drop_pulse one cycle, no out_valid for id=2, next entry id=4 presented.
REQ-034 id=1 in PRESENT, kill id=1 with out_ready=0 -> out_valid stays 1, payload unchanged, delivered when out_ready=1.
REQ-035 Full buffer, simultaneous pop and in_valid -> push refused (in_ready=0), count=3 afterward.
REQ-036 Without RESULT_KILL_FILTER_EN, repeat REQ-033 stimulus -> id=2 presented, drop_pulse never asserted.
